// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared types and encodings for the ID-stage branch hazard controller.
package branch_hazard_ctrl_pkg;

  // D-stage instruction IDs, as produced by the decoder.
  localparam logic [10:0] I_NOP  = 11'd0;
  localparam logic [10:0] I_ADDU = 11'd1;
  localparam logic [10:0] I_LW   = 11'd2;
  localparam logic [10:0] I_BEQ  = 11'd3;
  localparam logic [10:0] I_BNE  = 11'd4;
  localparam logic [10:0] I_BLEZ = 11'd5;
  localparam logic [10:0] I_BGTZ = 11'd6;
  localparam logic [10:0] I_BLTZ = 11'd7;
  localparam logic [10:0] I_BGEZ = 11'd8;
  localparam logic [10:0] I_SW   = 11'd9;

  // Comparator operand source select.
  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  // Result latency after entering E.
  localparam logic [1:0] TNEW_NONE = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  // One in-flight register writer.
  typedef struct packed {
    logic [4:0] addr;
    logic [1:0] tnew;
  } sb_entry_t;

  function automatic logic isBranchId(input logic [10:0] id);
    return (id == I_BEQ) || (id == I_BNE) || (id == I_BLEZ) ||
           (id == I_BGTZ) || (id == I_BLTZ) || (id == I_BGEZ);
  endfunction

  function automatic logic usesRtId(input logic [10:0] id);
    return (id == I_BEQ) || (id == I_BNE);
  endfunction

  // Age a producer by one stage; a finished result stays finished.
  function automatic logic [1:0] decTnew(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// D-stage / comparator / pipeline-control bundle of the branch hazard controller.
// No valid/ready handshake here: every signal is level-sampled each cycle. The
// decoder side (master) drives the D-stage fields, flush and cmpRes; the
// controller (slave) answers combinationally with stall/fwdSel/brTaken in the
// same cycle and keeps the counters registered.
interface branch_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic             flush;
  logic [10:0]      instrD_id;
  logic [4:0]       rsD;
  logic [4:0]       rtD;
  logic [4:0]       wrAddrD;
  logic [1:0]       tnewD;
  logic             cmpRes;
  logic             stall;
  logic [1:0]       fwdSelA;
  logic [1:0]       fwdSelB;
  logic             brTaken;
  logic [CNT_W-1:0] cntBranch;
  logic [CNT_W-1:0] cntTaken;
  logic [CNT_W-1:0] cntStall;

  modport master (
    output flush, instrD_id, rsD, rtD, wrAddrD, tnewD, cmpRes,
    input  stall, fwdSelA, fwdSelB, brTaken, cntBranch, cntTaken, cntStall
  );

  modport slave (
    input  flush, instrD_id, rsD, rtD, wrAddrD, tnewD, cmpRes,
    output stall, fwdSelA, fwdSelB, brTaken, cntBranch, cntTaken, cntStall
  );
endinterface

// File: rtl/branch_hazard_ctrl_sb_match.sv
// Looks up one source register against the E/M/W scoreboard entries.
module sb_match
  import branch_hazard_ctrl_pkg::*;
(
  input  logic [4:0] r,
  input  sb_entry_t  entE,
  input  sb_entry_t  entM,
  input  sb_entry_t  entW,
  output logic       hit,
  output logic       notReady,
  output logic [1:0] sel
);

  // Youngest matching writer wins; $0 never matches.
  always_comb begin
    hit      = 1'b0;
    notReady = 1'b0;
    sel      = FWD_GRF;
    if (r != 5'd0) begin
      if (entE.addr == r) begin
        hit      = 1'b1;
        notReady = (entE.tnew != 2'd0);
        sel      = FWD_E;
      end else if (entM.addr == r) begin
        hit      = 1'b1;
        notReady = (entM.tnew != 2'd0);
        sel      = FWD_M;
      end else if (entW.addr == r) begin
        hit      = 1'b1;
        notReady = (entW.tnew != 2'd0);
        sel      = FWD_W;
      end
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard controller: scoreboard of E/M/W writers, operand
// forwarding select, D/F stall and branch performance counters.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_hazard_ctrl_if.slave   bus
);

  sb_entry_t sbE, sbM, sbW;
  logic      hitA, hitB, nrA, nrB;
  logic [1:0] selA, selB;
  logic      isBranch, useRt, stallInt, branchDone;
  logic [CNT_W-1:0] cntBranch, cntTaken, cntStall;

  sb_match uMatchA (
    .r(bus.rsD), .entE(sbE), .entM(sbM), .entW(sbW),
    .hit(hitA), .notReady(nrA), .sel(selA)
  );

  sb_match uMatchB (
    .r(bus.rtD), .entE(sbE), .entM(sbM), .entW(sbW),
    .hit(hitB), .notReady(nrB), .sel(selB)
  );

  // Hazard decision and forwarding, purely from scoreboard state and D inputs.
  always_comb begin
    isBranch   = isBranchId(bus.instrD_id);
    useRt      = usesRtId(bus.instrD_id);
    stallInt   = isBranch & ((hitA & nrA) | (useRt & hitB & nrB));
    branchDone = isBranch & ~stallInt & ~bus.flush;
    // A not-yet-produced operand has nothing to forward; report the GRF.
    bus.fwdSelA = (hitA & ~nrA) ? selA : FWD_GRF;
    bus.fwdSelB = (useRt & hitB & ~nrB) ? selB : FWD_GRF;
    bus.stall   = stallInt;
    bus.brTaken = branchDone & bus.cmpRes;
  end

  // Scoreboard shift; flush/reset empty it, a stall injects a bubble into E.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      sbE <= '0;
      sbM <= '0;
      sbW <= '0;
    end else begin
      sbW <= '{addr: sbM.addr, tnew: decTnew(sbM.tnew)};
      sbM <= '{addr: sbE.addr, tnew: decTnew(sbE.tnew)};
      if (stallInt) sbE <= '0;
      else          sbE <= '{addr: bus.wrAddrD, tnew: bus.tnewD};
    end
  end

  // Performance counters; only reset clears them, flush just suppresses counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      cntBranch <= '0;
      cntTaken  <= '0;
      cntStall  <= '0;
    end else begin
      if (branchDone)             cntBranch <= cntBranch + 1'b1;
      if (branchDone & bus.cmpRes) cntTaken <= cntTaken + 1'b1;
      if (stallInt & ~bus.flush)  cntStall  <= cntStall + 1'b1;
    end
  end

  assign bus.cntBranch = cntBranch;
  assign bus.cntTaken  = cntTaken;
  assign bus.cntStall  = cntStall;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: directed hazard scenarios followed by random
// traffic, all checked against a producer-history model.
module tb_branch_hazard_ctrl;
  import branch_hazard_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  branch_hazard_ctrl_if #(.CNT_W(32)) bus ();

  branch_hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each producer is remembered with the cycle it sits in E; its stage is its
  // age and its result exists once age >= tnew.
  typedef struct {
    logic [4:0] addr;
    int         tnew;
    int         cyc;
  } prod_t;

  prod_t       hist[$];
  int          curCyc;
  logic [31:0] mBranch, mTaken, mStall;
  logic        obsStall, obsBr;
  logic [1:0]  obsSelA, obsSelB;

  task automatic lookup(input logic [4:0] r, output logic [1:0] sel, output logic nr);
    int age;
    sel = 2'd0;
    nr  = 1'b0;
    if (r != 5'd0) begin
      for (int i = hist.size() - 1; i >= 0; i--) begin
        age = curCyc - hist[i].cyc;
        if (age >= 0 && age <= 2 && hist[i].addr == r) begin
          nr  = (age < hist[i].tnew);
          sel = nr ? 2'd0 : 2'(age + 1);
          break;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // ---------------- driver ----------------
  task automatic doReset();
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.instrD_id = I_NOP;
    bus.rsD = 5'd0; bus.rtD = 5'd0; bus.wrAddrD = 5'd0;
    bus.tnewD = 2'd0; bus.cmpRes = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    hist.delete();
    curCyc = 0;
    mBranch = '0; mTaken = '0; mStall = '0;
  endtask

  // Drive one D-stage cycle, compare everything against the model, then clock.
  task automatic step(input logic [10:0] id, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] wr, input logic [1:0] tn, input logic cmp,
                      input logic fl);
    logic [1:0] eA, eB;
    logic nA, nB, br, ur, eSt, eTk;
    prod_t p;
    bus.instrD_id = id; bus.rsD = rs; bus.rtD = rt; bus.wrAddrD = wr;
    bus.tnewD = tn; bus.cmpRes = cmp; bus.flush = fl;
    #1;
    lookup(rs, eA, nA);
    lookup(rt, eB, nB);
    br  = id inside {I_BEQ, I_BNE, I_BLEZ, I_BGTZ, I_BLTZ, I_BGEZ};
    ur  = id inside {I_BEQ, I_BNE};
    eSt = br & (nA | (ur & nB));
    eTk = br & ~eSt & ~fl & cmp;
    obsStall = bus.stall; obsBr = bus.brTaken;
    obsSelA = bus.fwdSelA; obsSelB = bus.fwdSelB;
    chk("stall", 32'(bus.stall), 32'(eSt));
    chk("brTaken", 32'(bus.brTaken), 32'(eTk));
    if (!nA) chk("fwdSelA", 32'(bus.fwdSelA), 32'(eA));
    if (!ur) chk("fwdSelB_ignored", 32'(bus.fwdSelB), 32'd0);
    else if (!nB) chk("fwdSelB", 32'(bus.fwdSelB), 32'(eB));
    chk("cntBranch", bus.cntBranch, mBranch);
    chk("cntTaken", bus.cntTaken, mTaken);
    chk("cntStall", bus.cntStall, mStall);
    @(posedge clk);
    if (br & ~eSt & ~fl) mBranch++;
    if (eTk)             mTaken++;
    if (eSt & ~fl)       mStall++;
    if (fl) hist.delete();
    else if (!eSt) begin
      p.addr = wr; p.tnew = int'(tn); p.cyc = curCyc + 1;
      hist.push_back(p);
    end
    curCyc++;
    while (hist.size() > 0 && curCyc - hist[0].cyc > 2) void'(hist.pop_front());
    #1;
  endtask

  task automatic nop();
    step(I_NOP, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus and scoreboard report ----------------
  logic [10:0] ids[10] = '{I_NOP, I_ADDU, I_LW, I_SW, I_BEQ, I_BNE,
                           I_BLEZ, I_BGTZ, I_BLTZ, I_BGEZ};

  initial begin
    checks = 0; failures = 0;

    // 1: reset state
    doReset();
    nop();
    chk("rst_stall", 32'(obsStall), 32'd0);
    chk("rst_selA", 32'(obsSelA), 32'd0);
    chk("rst_cnt", bus.cntBranch | bus.cntTaken | bus.cntStall, 32'd0);

    // 2: load feeding beq
    doReset();
    step(I_LW, 5'd0, 5'd0, 5'd8, TNEW_LOAD, 1'b0, 1'b0);
    step(I_BEQ, 5'd8, 5'd9, 5'd0, 2'd0, 1'b0, 1'b0);
    chk("c2_stall1", 32'(obsStall), 32'd1);
    step(I_BEQ, 5'd8, 5'd9, 5'd0, 2'd0, 1'b0, 1'b0);
    chk("c2_stall2", 32'(obsStall), 32'd1);
    step(I_BEQ, 5'd8, 5'd9, 5'd0, 2'd0, 1'b0, 1'b0);
    chk("c2_go", 32'(obsStall), 32'd0);
    chk("c2_selB", 32'(obsSelB), 32'd0);
    nop();
    chk("c2_cntStall", bus.cntStall, 32'd2);
    chk("c2_cntBranch", bus.cntBranch, 32'd1);

    // 3: ALU feeding bgtz; a pending load on rt must not stall it
    doReset();
    step(I_LW, 5'd0, 5'd0, 5'd10, TNEW_LOAD, 1'b0, 1'b0);
    step(I_ADDU, 5'd0, 5'd0, 5'd9, TNEW_ALU, 1'b0, 1'b0);
    step(I_BGTZ, 5'd9, 5'd10, 5'd0, 2'd0, 1'b1, 1'b0);
    chk("c3_stall1", 32'(obsStall), 32'd1);
    step(I_BGTZ, 5'd9, 5'd10, 5'd0, 2'd0, 1'b1, 1'b0);
    chk("c3_norstall", 32'(obsStall), 32'd0);
    chk("c3_selA", 32'(obsSelA), 32'(FWD_M));
    chk("c3_selB", 32'(obsSelB), 32'd0);

    // 4: writes to $0 never hazard
    doReset();
    step(I_ADDU, 5'd0, 5'd0, 5'd0, TNEW_ALU, 1'b0, 1'b0);
    step(I_BEQ, 5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 1'b0);
    chk("c4_stall", 32'(obsStall), 32'd0);
    chk("c4_taken", 32'(obsBr), 32'd1);
    nop();
    chk("c4_cntTaken", bus.cntTaken, 32'd1);

    // 5: youngest writer wins
    doReset();
    step(I_ADDU, 5'd0, 5'd0, 5'd11, TNEW_NONE, 1'b0, 1'b0);
    step(I_ADDU, 5'd0, 5'd0, 5'd11, TNEW_NONE, 1'b0, 1'b0);
    step(I_BNE, 5'd11, 5'd11, 5'd0, 2'd0, 1'b0, 1'b0);
    chk("c5_EoverM", 32'(obsSelA), 32'(FWD_E));
    step(I_ADDU, 5'd0, 5'd0, 5'd11, TNEW_NONE, 1'b0, 1'b0);
    step(I_ADDU, 5'd0, 5'd0, 5'd11, TNEW_NONE, 1'b0, 1'b0);
    step(I_ADDU, 5'd0, 5'd0, 5'd12, TNEW_NONE, 1'b0, 1'b0);
    step(I_BEQ, 5'd11, 5'd12, 5'd0, 2'd0, 1'b0, 1'b0);
    chk("c5_MoverW", 32'(obsSelA), 32'(FWD_M));

    // 6: flush in the first stall cycle
    doReset();
    step(I_LW, 5'd0, 5'd0, 5'd8, TNEW_LOAD, 1'b0, 1'b0);
    step(I_BEQ, 5'd8, 5'd9, 5'd0, 2'd0, 1'b0, 1'b1);
    chk("c6_stallAtFlush", 32'(obsStall), 32'd1);
    step(I_BEQ, 5'd8, 5'd9, 5'd0, 2'd0, 1'b0, 1'b0);
    chk("c6_stallAfter", 32'(obsStall), 32'd0);
    chk("c6_sel", 32'(obsSelA), 32'd0);
    nop();
    chk("c6_cntBranch", bus.cntBranch, 32'd1);

    // random traffic on a small register pool to provoke collisions
    doReset();
    for (int n = 0; n < 600; n++) begin
      step(ids[$urandom_range(0, 9)],
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
